// File: rtl/gcd_stream_pkg.sv
// Shared constants and types for the XGCD result streamer.
// Frame geometry: one header beat, then NB beats of coefficient A, then
// NB beats of coefficient B. All beats are LSB-first slices of the
// coefficients, which are zero-padded up to a whole number of beats.
package gcd_stream_pkg;

    localparam int COEF_W      = 1284;
    localparam int BEAT_W      = 64;
    localparam int CNT_W       = 12;
    localparam int NB          = (COEF_W + BEAT_W - 1) / BEAT_W;
    localparam int FRAME_BEATS = 1 + 2 * NB;
    localparam int PAD_W       = NB * BEAT_W;

    localparam logic [15:0] HDR_MAGIC = 16'hBE20;

    typedef logic [5:0] beat_idx_t;

    localparam beat_idx_t LAST_IDX = beat_idx_t'(FRAME_BEATS - 1);

    typedef enum logic [1:0] {
        TAG_HDR    = 2'd0,
        TAG_COEF_A = 2'd1,
        TAG_COEF_B = 2'd2
    } beat_tag_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/gcd_beat_slicer.sv
// Combinational beat mux: maps the beat index and the snapshot registers
// to the data, tag and last flag of the current beat.
//   idx_i      : beat index, 0 = header, 1..NB = A, NB+1..2*NB = B
//   snap_a_i   : coefficient A snapshot
//   snap_b_i   : coefficient B snapshot
//   snap_cnt_i : cycle-count snapshot
//   tdata_o    : beat data
//   tuser_o    : beat tag
//   tlast_o    : high on the final beat of the frame
module gcd_beat_slicer
    import gcd_stream_pkg::*;
(
    input  logic [5:0]        idx_i,
    input  logic [COEF_W-1:0] snap_a_i,
    input  logic [COEF_W-1:0] snap_b_i,
    input  logic [CNT_W-1:0]  snap_cnt_i,
    output logic [BEAT_W-1:0] tdata_o,
    output logic [1:0]        tuser_o,
    output logic              tlast_o
);

    logic [PAD_W-1:0] pad_a;
    logic [PAD_W-1:0] pad_b;
    beat_tag_e        tag;

    // Bits above COEF_W read as zero in the last beat of each coefficient.
    assign pad_a = {{(PAD_W - COEF_W){1'b0}}, snap_a_i};
    assign pad_b = {{(PAD_W - COEF_W){1'b0}}, snap_b_i};

    always_comb begin
        tag     = TAG_HDR;
        tdata_o = '0;
        if (idx_i == 6'd0) begin
            tdata_o = {HDR_MAGIC, 8'h00, 8'(2 * NB), 20'h0_0000, snap_cnt_i};
        end else if (idx_i <= 6'(NB)) begin
            tag     = TAG_COEF_A;
            tdata_o = BEAT_W'(pad_a >> (BEAT_W * (int'(idx_i) - 1)));
        end else begin
            tag     = TAG_COEF_B;
            tdata_o = BEAT_W'(pad_b >> (BEAT_W * (int'(idx_i) - 1 - NB)));
        end
    end

    assign tuser_o = tag;
    assign tlast_o = (beat_idx_t'(idx_i) == LAST_IDX);

endmodule

// File: rtl/gcd_result_streamer.sv
// Snapshots each XGCD result on DONE_PULSE and drains it as a 64-bit
// valid/ready frame (header, coefficient A, coefficient B).
//   CLK, RESET          : divided interface clock, synchronous active-high reset
//   DONE_PULSE          : result strobe; BEZOUT_A/B and CYCLE_COUNT valid with it
//   M_TDATA/TVALID/TREADY/TLAST/TUSER : beat stream, TUSER = beat tag
//   BUSY                : frame in flight
//   IRQ                 : sticky, set when the last beat is accepted
//   OVERRUN             : sticky, set when a result is dropped mid-frame
//   IRQ_CLR             : clears IRQ and OVERRUN (a same-cycle set wins)
//
// state     | meaning
// ST_IDLE   | no frame; waiting for DONE_PULSE
// ST_STREAM | presenting beat idx_q; advances on each handshake
module gcd_result_streamer
    import gcd_stream_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DONE_PULSE,
    input  logic [COEF_W-1:0] BEZOUT_A,
    input  logic [COEF_W-1:0] BEZOUT_B,
    input  logic [CNT_W-1:0]  CYCLE_COUNT,
    output logic [BEAT_W-1:0] M_TDATA,
    output logic              M_TVALID,
    input  logic              M_TREADY,
    output logic              M_TLAST,
    output logic [1:0]        M_TUSER,
    output logic              BUSY,
    output logic              IRQ,
    input  logic              IRQ_CLR,
    output logic              OVERRUN
);

    state_e            state_q, state_d;
    beat_idx_t         idx_q, idx_d;
    logic              irq_q, irq_d;
    logic              overrun_q, overrun_d;
    logic [COEF_W-1:0] snap_a_q, snap_b_q;
    logic [CNT_W-1:0]  snap_cnt_q;

    logic              valid;
    logic              hs;
    logic              last_hs;
    logic              load;
    logic              irq_set;
    logic              overrun_set;

    logic [BEAT_W-1:0] slice_data;
    logic [1:0]        slice_user;
    logic              slice_last;

    assign valid   = (state_q == ST_STREAM);
    assign hs      = valid & M_TREADY;
    assign last_hs = hs & (idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        load        = 1'b0;
        irq_set     = 1'b0;
        overrun_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (DONE_PULSE) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (last_hs) begin
                    irq_set = 1'b1;
                    idx_d   = '0;
                    // A result arriving with the final handshake starts the
                    // next frame directly, without an idle cycle.
                    if (DONE_PULSE) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (hs) begin
                        idx_d = idx_q + 6'd1;
                    end
                    if (DONE_PULSE) begin
                        overrun_set = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        irq_d     = irq_set | (irq_q & ~IRQ_CLR);
        overrun_d = overrun_set | (overrun_q & ~IRQ_CLR);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            irq_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            irq_q     <= irq_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            snap_a_q   <= '0;
            snap_b_q   <= '0;
            snap_cnt_q <= '0;
        end else if (load) begin
            snap_a_q   <= BEZOUT_A;
            snap_b_q   <= BEZOUT_B;
            snap_cnt_q <= CYCLE_COUNT;
        end
    end

    gcd_beat_slicer u_slicer (
        .idx_i      (idx_q),
        .snap_a_i   (snap_a_q),
        .snap_b_i   (snap_b_q),
        .snap_cnt_i (snap_cnt_q),
        .tdata_o    (slice_data),
        .tuser_o    (slice_user),
        .tlast_o    (slice_last)
    );

    // Beat fields are forced to zero outside a frame so that idle and reset
    // present an all-zero interface.
    assign M_TDATA  = valid ? slice_data : '0;
    assign M_TUSER  = valid ? slice_user : 2'd0;
    assign M_TLAST  = valid & slice_last;
    assign M_TVALID = valid;
    assign BUSY     = valid;
    assign IRQ      = irq_q;
    assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_gcd_result_streamer.sv
module tb_gcd_result_streamer;

    localparam int CW = 1284;
    localparam int NBEATS = 43;

    typedef logic [66:0] beat_t;   // {last, user[1:0], data[63:0]}

    typedef struct {
        int          idx;
        logic [63:0] data;
        logic [1:0]  user;
        logic        last;
    } dvec_t;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          DONE_PULSE;
    logic [CW-1:0] BEZOUT_A;
    logic [CW-1:0] BEZOUT_B;
    logic [11:0]   CYCLE_COUNT;
    logic [63:0]   M_TDATA;
    logic          M_TVALID;
    logic          M_TREADY;
    logic          M_TLAST;
    logic [1:0]    M_TUSER;
    logic          BUSY;
    logic          IRQ;
    logic          IRQ_CLR;
    logic          OVERRUN;

    int n_vec = 0;
    int n_err = 0;

    beat_t cap_q[$];
    beat_t exp_q[$];
    beat_t last_f[NBEATS];

    gcd_result_streamer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .DONE_PULSE  (DONE_PULSE),
        .BEZOUT_A    (BEZOUT_A),
        .BEZOUT_B    (BEZOUT_B),
        .CYCLE_COUNT (CYCLE_COUNT),
        .M_TDATA     (M_TDATA),
        .M_TVALID    (M_TVALID),
        .M_TREADY    (M_TREADY),
        .M_TLAST     (M_TLAST),
        .M_TUSER     (M_TUSER),
        .BUSY        (BUSY),
        .IRQ         (IRQ),
        .IRQ_CLR     (IRQ_CLR),
        .OVERRUN     (OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stream monitor: records accepted beats and checks the valid/ready rules.
    logic  prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1, prev_last = 1'b0;
    beat_t prev_b = '0;
    always @(negedge CLK) begin
        if (prev_v && !prev_rst && !(prev_r && prev_last))
            chk("tvalid_no_gap", 128'(M_TVALID), 128'(1));
        if (prev_v && !prev_r && !prev_rst)
            chk("stall_stable", 128'({M_TLAST, M_TUSER, M_TDATA}), 128'(prev_b));
        if (!RESET && M_TVALID && M_TREADY)
            cap_q.push_back({M_TLAST, M_TUSER, M_TDATA});
        prev_v    = M_TVALID;
        prev_r    = M_TREADY;
        prev_rst  = RESET;
        prev_last = M_TLAST;
        prev_b    = {M_TLAST, M_TUSER, M_TDATA};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [CW-1:0] rand_coef();
        logic [1311:0] t;
        for (int k = 0; k < 41; k++) t[k*32 +: 32] = $urandom;
        return t[CW-1:0];
    endfunction

    // Reference frame: header word, then each coefficient peeled 64 bits at a time.
    task automatic build_frame(input logic [CW-1:0] a, input logic [CW-1:0] b, input logic [11:0] c);
        logic [1343:0] t;
        exp_q.delete();
        exp_q.push_back({1'b0, 2'd0, 64'hBE20_002A_0000_0000 | 64'(c)});
        t = 1344'(a);
        for (int k = 0; k < 21; k++) begin
            exp_q.push_back({1'b0, 2'd1, t[63:0]});
            t = t >> 64;
        end
        t = 1344'(b);
        for (int k = 0; k < 21; k++) begin
            exp_q.push_back({1'b0, 2'd2, t[63:0]});
            t = t >> 64;
        end
        exp_q[NBEATS-1][66] = 1'b1;
    endtask

    task automatic pulse(input logic [CW-1:0] a, input logic [CW-1:0] b, input logic [11:0] c);
        BEZOUT_A    = a;
        BEZOUT_B    = b;
        CYCLE_COUNT = c;
        DONE_PULSE  = 1'b1;
        tick();
        DONE_PULSE  = 1'b0;
        BEZOUT_A    = ~a;
        BEZOUT_B    = ~b;
        CYCLE_COUNT = ~c;
    endtask

    task automatic run_until(input int target, input int budget, input bit rnd);
        int n = 0;
        while (cap_q.size() < target && n < budget) begin
            if (rnd) M_TREADY = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk($sformatf("beats_reached_%0d", target), 128'(cap_q.size() >= target), 128'(1));
    endtask

    task automatic compare_frame(input string name);
        for (int i = 0; i < NBEATS; i++) begin
            beat_t g;
            g = (cap_q.size() > 0) ? cap_q.pop_front() : 'x;
            last_f[i] = g;
            chk($sformatf("%s_beat%0d", name, i), 128'(g), 128'(exp_q[i]));
        end
    endtask

    dvec_t tbl[10];
    logic [CW-1:0] a1, b1, ax, bx;
    logic [11:0]   c1, cx;

    initial begin
        tbl[0] = '{0,  64'hBE20_002A_0000_03A5, 2'd0, 1'b0};
        tbl[1] = '{1,  64'h1,                   2'd1, 1'b0};
        tbl[2] = '{2,  64'h0,                   2'd1, 1'b0};
        tbl[3] = '{11, 64'h0,                   2'd1, 1'b0};
        tbl[4] = '{20, 64'h0,                   2'd1, 1'b0};
        tbl[5] = '{21, 64'h0,                   2'd1, 1'b0};
        tbl[6] = '{22, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 1'b0};
        tbl[7] = '{30, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 1'b0};
        tbl[8] = '{41, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 1'b0};
        tbl[9] = '{42, 64'hF,                   2'd2, 1'b1};

        RESET = 1'b1; DONE_PULSE = 1'b0; BEZOUT_A = '0; BEZOUT_B = '0;
        CYCLE_COUNT = '0; M_TREADY = 1'b0; IRQ_CLR = 1'b0;
        tick(); tick(); tick();
        chk("rst_tvalid",  128'(M_TVALID), 128'(0));
        chk("rst_busy",    128'(BUSY),     128'(0));
        chk("rst_irq",     128'(IRQ),      128'(0));
        chk("rst_overrun", 128'(OVERRUN),  128'(0));
        chk("rst_tdata",   128'(M_TDATA),  128'(0));
        chk("rst_tlast",   128'(M_TLAST),  128'(0));
        chk("rst_tuser",   128'(M_TUSER),  128'(0));
        RESET = 1'b0;
        tick();

        // Directed frame, sink always ready.
        M_TREADY = 1'b1;
        a1 = CW'(1); b1 = '1; c1 = 12'h3A5;
        build_frame(a1, b1, c1);
        chk("f1_idle_before", 128'(M_TVALID), 128'(0));
        pulse(a1, b1, c1);
        chk("f1_tvalid_next", 128'(M_TVALID), 128'(1));
        chk("f1_busy_next",   128'(BUSY),     128'(1));
        run_until(NBEATS, 100, 0);
        chk("f1_irq",         128'(IRQ),      128'(1));
        chk("f1_tvalid_end",  128'(M_TVALID), 128'(0));
        chk("f1_busy_end",    128'(BUSY),     128'(0));
        compare_frame("f1");
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tbl_data_%0d", tbl[i].idx), 128'(last_f[tbl[i].idx][63:0]), 128'(tbl[i].data));
            chk($sformatf("tbl_user_%0d", tbl[i].idx), 128'(last_f[tbl[i].idx][65:64]), 128'(tbl[i].user));
            chk($sformatf("tbl_last_%0d", tbl[i].idx), 128'(last_f[tbl[i].idx][66]), 128'(tbl[i].last));
        end

        IRQ_CLR = 1'b1; tick(); IRQ_CLR = 1'b0;
        chk("clr1_irq", 128'(IRQ), 128'(0));

        // Dropped result at beat 10, then IRQ_CLR together with the final handshake.
        pulse(a1, b1, c1);
        run_until(10, 100, 0);
        pulse(rand_coef(), rand_coef(), 12'($urandom));
        chk("f2_overrun_set", 128'(OVERRUN), 128'(1));
        run_until(42, 100, 0);
        IRQ_CLR = 1'b1; tick(); IRQ_CLR = 1'b0;
        chk("f2_irq_set_wins",  128'(IRQ),     128'(1));
        chk("f2_overrun_clear", 128'(OVERRUN), 128'(0));
        compare_frame("f2");
        chk("f2_no_extra", 128'(cap_q.size()), 128'(0));
        IRQ_CLR = 1'b1; tick(); IRQ_CLR = 1'b0;

        // Random data with a randomly stalling sink.
        for (int f = 0; f < 4; f++) begin
            int ovr_at;
            ax = rand_coef(); bx = rand_coef(); cx = 12'($urandom);
            build_frame(ax, bx, cx);
            pulse(ax, bx, cx);
            ovr_at = (f % 2 == 1) ? int'($urandom_range(2, 30)) : 0;
            if (ovr_at != 0) begin
                run_until(ovr_at, 400, 1);
                pulse(rand_coef(), rand_coef(), 12'($urandom));
                chk("rnd_overrun_set", 128'(OVERRUN), 128'(1));
            end
            run_until(NBEATS, 400, 1);
            M_TREADY = 1'b1;
            chk("rnd_irq",     128'(IRQ),     128'(1));
            chk("rnd_overrun", 128'(OVERRUN), 128'(ovr_at != 0));
            compare_frame($sformatf("rnd%0d", f));
            chk("rnd_no_extra", 128'(cap_q.size()), 128'(0));
            IRQ_CLR = 1'b1; tick(); IRQ_CLR = 1'b0;
            chk("rnd_clr_irq",     128'(IRQ),     128'(0));
            chk("rnd_clr_overrun", 128'(OVERRUN), 128'(0));
        end

        // New result coincident with the final handshake.
        M_TREADY = 1'b1;
        ax = rand_coef(); bx = rand_coef(); cx = 12'($urandom);
        build_frame(ax, bx, cx);
        pulse(ax, bx, cx);
        run_until(42, 100, 0);
        a1 = rand_coef(); b1 = rand_coef();
        pulse(a1, b1, 12'h001);
        chk("b2b_tvalid",  128'(M_TVALID), 128'(1));
        chk("b2b_header",  128'(M_TDATA),  128'(64'hBE20_002A_0000_0001));
        chk("b2b_tuser",   128'(M_TUSER),  128'(0));
        chk("b2b_irq",     128'(IRQ),      128'(1));
        chk("b2b_overrun", 128'(OVERRUN),  128'(0));
        compare_frame("b2b_x");
        build_frame(a1, b1, 12'h001);
        run_until(NBEATS, 100, 0);
        compare_frame("b2b_y");
        chk("b2b_no_extra", 128'(cap_q.size()), 128'(0));

        // Reset in the middle of a frame, then restart.
        ax = rand_coef(); bx = rand_coef(); cx = 12'($urandom);
        pulse(ax, bx, cx);
        run_until(3, 100, 0);
        pulse(rand_coef(), rand_coef(), 12'($urandom));
        run_until(5, 100, 0);
        RESET = 1'b1; tick();
        chk("mrst_tvalid",  128'(M_TVALID), 128'(0));
        chk("mrst_busy",    128'(BUSY),     128'(0));
        chk("mrst_irq",     128'(IRQ),      128'(0));
        chk("mrst_overrun", 128'(OVERRUN),  128'(0));
        chk("mrst_tdata",   128'(M_TDATA),  128'(0));
        RESET = 1'b0;
        tick();
        chk("mrst_stays_idle", 128'(M_TVALID), 128'(0));
        cap_q.delete();
        ax = rand_coef(); bx = rand_coef(); cx = 12'($urandom);
        build_frame(ax, bx, cx);
        pulse(ax, bx, cx);
        run_until(NBEATS, 100, 0);
        compare_frame("after_rst");
        chk("after_rst_irq", 128'(IRQ), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
